edge_detect_bank: RTL and testbench

Parametrised multi-channel edge detector. It synchronises CHANNELS asynchronous level inputs, deglitches each one with a consecutive-sample filter, and produces one-cycle pulses on rising, falling or both edges, selected per channel at run time. Each channel also has a sticky event flag, and the flags are combined into one interrupt request. It sits between board-level control/status lines and the control logic, and handles many lines at once where each line would otherwise need its own single-signal detector.

---
 rtl/edge_detect_bank.sv | 147 ++++++++++++++
 tb/tb_edge_detect_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_bank.sv
// Multi-channel edge detector: synchroniser, per-channel deglitch filter, edge pulses, sticky flags and IRQ.
// Build option: define EDGE_DETECT_BANK_FILTER_EN to include the consecutive-sample filter.
module edge_detect_bank #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] LONG_SIGNAL,
    input  logic [CHANNELS-1:0] RISE_EN,
    input  logic [CHANNELS-1:0] FALL_EN,
    input  logic [CHANNELS-1:0] FLAG_CLEAR,
    output logic [CHANNELS-1:0] LEVEL,
    output logic [CHANNELS-1:0] EDGE_PULSE,
    output logic [CHANNELS-1:0] EVENT_FLAG,
    output logic                IRQ
);

`ifdef EDGE_DETECT_BANK_FILTER_EN
    localparam int FLEN_EFF = FILTER_LEN;
`else
    // Filter compiled out: behaves as a one-sample filter.
    localparam int FLEN_EFF = (FILTER_LEN >= 1) ? 1 : 1;
`endif
    localparam int WU  = SYNC_STAGES + FLEN_EFF;
    localparam int WUW = $clog2(WU + 1);

    typedef enum logic {ST_WARMUP, ST_RUN} state_e;

    state_e               state_q, state_d;
    logic [WUW-1:0]       wu_q, wu_d;
    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]  sync_out;
    logic [CHANNELS-1:0]  level_q, level_d;
    logic [CHANNELS-1:0]  pulse_q, pulse_d;
    logic [CHANNELS-1:0]  flag_q, flag_d;
    logic                 irq_q, irq_d;
    logic [CHANNELS-1:0]  rise, fall;
    logic                 warm;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= LONG_SIGNAL;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_WARMUP;
            wu_q    <= WUW'(WU);
        end else begin
            state_q <= state_d;
            wu_q    <= wu_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wu_d    = wu_q;
        case (state_q)
            ST_WARMUP: begin
                wu_d = wu_q - 1'b1;
                if (wu_q == WUW'(1)) state_d = ST_RUN;
            end
            ST_RUN: wu_d = '0;
            default: state_d = ST_WARMUP;
        endcase
    end

    assign warm = (state_q == ST_WARMUP);

`ifdef EDGE_DETECT_BANK_FILTER_EN
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [CW-1:0] cnt_q [CHANNELS];
    logic [CW-1:0] cnt_d [CHANNELS];

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (warm) begin
                level_d[i] = sync_out[i];
                cnt_d[i]   = '0;
            end else if (sync_out[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
                level_d[i] = ~level_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end
`else
    always_comb begin
        level_d = sync_out;
    end
`endif

    // Edges are judged on the LEVEL transition itself, so pulses are suppressed during warm-up.
    always_comb begin
        rise    = ~level_q & level_d;
        fall    = level_q & ~level_d;
        pulse_d = '0;
        flag_d  = '0;
        if (!warm) begin
            pulse_d = (rise & RISE_EN) | (fall & FALL_EN);
            flag_d  = pulse_d | (flag_q & ~FLAG_CLEAR);
        end
        irq_d = |flag_d;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            level_q <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            irq_q   <= irq_d;
        end
    end

    assign LEVEL      = level_q;
    assign EDGE_PULSE = pulse_q;
    assign EVENT_FLAG = flag_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_edge_detect_bank.sv
// Directed self-checking bench for edge_detect_bank with default parameters.
module tb_edge_detect_bank;

`ifdef EDGE_DETECT_BANK_FILTER_EN
    localparam int FLT = 4;
`else
    localparam int FLT = 1;
`endif
    localparam int LAT = 2 + FLT - 1;   // edges after edge k at which LEVEL/EDGE_PULSE rise
    localparam int WU  = 2 + FLT;

    logic       CLOCK;
    logic       RESET;
    logic [7:0] LONG_SIGNAL, RISE_EN, FALL_EN, FLAG_CLEAR;
    logic [7:0] LEVEL, EDGE_PULSE, EVENT_FLAG;
    logic       IRQ;

    int tests;
    int fails;

    edge_detect_bank #(
        .CHANNELS    (8),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .LONG_SIGNAL (LONG_SIGNAL),
        .RISE_EN     (RISE_EN),
        .FALL_EN     (FALL_EN),
        .FLAG_CLEAR  (FLAG_CLEAR),
        .LEVEL       (LEVEL),
        .EDGE_PULSE  (EDGE_PULSE),
        .EVENT_FLAG  (EVENT_FLAG),
        .IRQ         (IRQ)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] lvl, input logic [7:0] pls,
                           input logic [7:0] flg, input logic irq);
        chk({tag, ".level"}, LEVEL, lvl);
        chk({tag, ".pulse"}, EDGE_PULSE, pls);
        chk({tag, ".flag"}, EVENT_FLAG, flg);
        chk({tag, ".irq"}, 8'(IRQ), 8'(irq));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RESET       = 1'b0;
        LONG_SIGNAL = 8'hFF;
        RISE_EN     = 8'hFF;
        FALL_EN     = 8'hFF;
        FLAG_CLEAR  = 8'h00;

        #3;
        chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        step();
        chk_all("reset_held", 8'h00, 8'h00, 8'h00, 1'b0);
        RESET = 1'b1;

        // Lines already high at release: LEVEL follows, never a pulse or flag.
        for (int s = 1; s <= WU + 3; s++) begin
            step();
            chk("warm_pulse", EDGE_PULSE, 8'h00);
            chk("warm_flag", EVENT_FLAG, 8'h00);
            chk("warm_irq", 8'(IRQ), 8'h00);
        end
        chk("warm_level", LEVEL, 8'hFF);

        // All lines fall with falling edges disabled.
        FALL_EN     = 8'h00;
        LONG_SIGNAL = 8'h00;
        for (int s = 1; s <= LAT + 3; s++) begin
            step();
            chk("fall_dis_pulse", EDGE_PULSE, 8'h00);
            chk("fall_dis_flag", EVENT_FLAG, 8'h00);
        end
        chk("fall_dis_level", LEVEL, 8'h00);

        // Channel 2 rises with FALL_EN still off: exactly one pulse.
        LONG_SIGNAL = 8'h04;
        for (int s = 1; s <= LAT; s++) begin
            step();
            chk_all("ch2_pre", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        step();
        chk_all("ch2_edge", 8'h04, 8'h04, 8'h04, 1'b1);
        step();
        chk_all("ch2_after", 8'h04, 8'h00, 8'h04, 1'b1);
        FLAG_CLEAR = 8'h04;
        step();
        FLAG_CLEAR = 8'h00;
        chk_all("ch2_clear", 8'h04, 8'h00, 8'h00, 1'b0);

        // Channel 0 rising step, all edges enabled.
        FALL_EN     = 8'hFF;
        LONG_SIGNAL = 8'h05;
        for (int s = 1; s <= LAT; s++) begin
            step();
            chk("ch0_pre_pulse", EDGE_PULSE, 8'h00);
            chk("ch0_pre_level", LEVEL, 8'h04);
        end
        step();
        chk_all("ch0_edge", 8'h05, 8'h01, 8'h01, 1'b1);
        step();
        chk_all("ch0_after", 8'h05, 8'h00, 8'h01, 1'b1);
        FLAG_CLEAR = 8'h01;
        step();
        FLAG_CLEAR = 8'h00;
        chk_all("ch0_clear", 8'h05, 8'h00, 8'h00, 1'b0);

`ifdef EDGE_DETECT_BANK_FILTER_EN
        // Three-cycle glitch on channel 3 is rejected.
        LONG_SIGNAL = 8'h0D;
        for (int s = 1; s <= LAT + 5; s++) begin
            step();
            if (s == 3) LONG_SIGNAL = 8'h05;
            chk_all("ch3_glitch", 8'h05, 8'h00, 8'h00, 1'b0);
        end
`endif

        // Four-cycle high on channel 3: rise pulse, then fall pulse four cycles later.
        LONG_SIGNAL = 8'h0D;
        for (int s = 1; s <= LAT + 6; s++) begin
            step();
            if (s == 4) LONG_SIGNAL = 8'h05;
            if (s == LAT + 1 || s == LAT + 5)
                chk("ch3_pulse_on", EDGE_PULSE, 8'h08);
            else
                chk("ch3_pulse_off", EDGE_PULSE, 8'h00);
            if (s >= LAT + 1 && s < LAT + 5)
                chk("ch3_level_hi", LEVEL, 8'h0D);
            else
                chk("ch3_level_lo", LEVEL, 8'h05);
        end
        chk("ch3_flag", EVENT_FLAG, 8'h08);
        FLAG_CLEAR = 8'h08;
        step();
        FLAG_CLEAR = 8'h00;
        chk_all("ch3_clear", 8'h05, 8'h00, 8'h00, 1'b0);

        // Channel 5: clear strobe coinciding with a new pulse keeps the flag.
        LONG_SIGNAL = 8'h25;
        for (int s = 1; s <= LAT + 1; s++) step();
        chk_all("ch5_rise", 8'h25, 8'h20, 8'h20, 1'b1);
        LONG_SIGNAL = 8'h05;
        for (int s = 1; s <= LAT; s++) step();
        chk_all("ch5_pre_fall", 8'h25, 8'h00, 8'h20, 1'b1);
        FLAG_CLEAR = 8'h20;
        step();
        FLAG_CLEAR = 8'h00;
        chk_all("ch5_set_wins", 8'h05, 8'h20, 8'h20, 1'b1);
        step();
        chk_all("ch5_hold", 8'h05, 8'h00, 8'h20, 1'b1);
        FLAG_CLEAR = 8'h20;
        step();
        FLAG_CLEAR = 8'h00;
        chk_all("ch5_clear", 8'h05, 8'h00, 8'h00, 1'b0);

        // Channel 1 transition interrupted by reset.
        LONG_SIGNAL = 8'h07;
        step();
        step();
        RESET = 1'b0;
        #1;
        chk_all("midreset", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        chk_all("midreset_held", 8'h00, 8'h00, 8'h00, 1'b0);
        RESET = 1'b1;
        for (int s = 1; s <= WU + 4; s++) begin
            step();
            chk("rewarm_pulse", EDGE_PULSE, 8'h00);
            chk("rewarm_flag", EVENT_FLAG, 8'h00);
            chk("rewarm_irq", 8'(IRQ), 8'h00);
        end
        chk("rewarm_level", LEVEL, 8'h07);

        // Simultaneous rises on channels 3 and 4.
        LONG_SIGNAL = 8'h1F;
        for (int s = 1; s <= LAT; s++) step();
        chk("multi_pre", EDGE_PULSE, 8'h00);
        step();
        chk_all("multi_edge", 8'h1F, 8'h18, 8'h18, 1'b1);
        step();
        chk_all("multi_after", 8'h1F, 8'h00, 8'h18, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
